// File: rtl/sram_sector_server_pkg.sv
// -----------------------------------------------------------------------------
// sram_sector_server_pkg
//   Shared constants for the SRAM sector server: sector geometry, default
//   SRAM address width and the FSM state encoding. The states are plain
//   localparam constants so that legacy tools and waveform decoders see a
//   fixed 3-bit code.
// -----------------------------------------------------------------------------
package sram_sector_server_pkg;

    localparam int SECTOR_BYTES        = 512;
    localparam int SECTOR_SHIFT        = 9;
    localparam int DEFAULT_ADDR_W      = 20;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    // Index of the final byte in a sector; the byte counter is compared
    // against this rather than relying on it wrapping to zero.
    localparam logic [SECTOR_SHIFT-1:0] LAST_BYTE = SECTOR_SHIFT'(SECTOR_BYTES - 1);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_RD_ADDR  = 3'd1;
    localparam state_t ST_RD_WAIT  = 3'd2;
    localparam state_t ST_RD_PUT   = 3'd3;
    localparam state_t ST_WR_FETCH = 3'd4;
    localparam state_t ST_WR_PULSE = 3'd5;
    localparam state_t ST_WR_HOLD  = 3'd6;
    localparam state_t ST_DONE     = 3'd7;

endpackage : sram_sector_server_pkg

// File: rtl/sram_sector_server_wait_timer.sv
// -----------------------------------------------------------------------------
// sram_wait_timer
//   Wait-state down-counter shared by the read wait and the write pulse.
//   Loading it makes zero_o go high exactly WAIT_CYCLES cycles later (the
//   load value is WAIT_CYCLES-1 and the loading state occupies one cycle
//   ahead of the timed window), so the timed state lasts WAIT_CYCLES cycles.
//
// Ports
//   clk_sys  in  system clock
//   reset_n  in  asynchronous active-low reset
//   load_i   in  (re)start the count
//   zero_o   out count has reached zero
// -----------------------------------------------------------------------------
module sram_wait_timer
    import sram_sector_server_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic load_i,
    output logic zero_o
);

    localparam logic [2:0] LOAD_VAL = 3'(WAIT_CYCLES - 1);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of block evaluation order.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 3'd0);

endmodule : sram_wait_timer

// File: rtl/sram_sector_server.sv
// -----------------------------------------------------------------------------
// sram_sector_server
//   Serves 512-byte floppy sector requests out of a disk image held in
//   byte-wide external SRAM. A rising edge on sd_rd / sd_wr (read wins when
//   both rise together) starts a transfer of one sector at sd_lba*512; the
//   bytes are streamed to / from the FDC sector buffer one at a time.
//
// Optional feature (macro SECTOR_RANGE_CHECK_EN):
//   Adds the img_size port. Sectors extending past the image run full length
//   but reads return 0x00 without driving the SRAM address and writes never
//   assert sram_we_o. Without the macro addresses simply wrap modulo
//   2^ADDR_W.
//
// Ports
//   clk_sys, reset_n      clock, asynchronous active-low reset
//   sd_lba[31:0]          sector number, sampled on acceptance
//   sd_rd, sd_wr          level read / write requests (edge detected)
//   sd_ack                high while a transfer is in progress
//   sd_buff_addr[8:0]     byte index within the sector
//   sd_buff_dout[7:0]     read byte toward the FDC buffer
//   sd_buff_wr            one-cycle strobe capturing sd_buff_dout
//   sd_buff_din[7:0]      byte from the FDC buffer (1-cycle latency)
//   sram_addr_o           SRAM byte address
//   sram_data_i/_o[7:0]   SRAM read / write data
//   sram_we_o             SRAM write enable, active high
//   img_size[31:0]        image size in bytes (SECTOR_RANGE_CHECK_EN only)
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module sram_sector_server
    import sram_sector_server_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [7:0]        sd_buff_din,
    output logic [ADDR_W-1:0] sram_addr_o,
    input  logic [7:0]        sram_data_i,
    output logic [7:0]        sram_data_o,
    output logic              sram_we_o
`ifdef SECTOR_RANGE_CHECK_EN
    ,
    input  logic [31:0]       img_size
`endif
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                   state_q,     state_d;
    logic                     rd_q,        rd_d;
    logic                     wr_q,        wr_d;
    logic                     ack_q,       ack_d;
    logic [SECTOR_SHIFT-1:0]  cnt_q,       cnt_d;
    logic [ADDR_W-1:0]        base_q,      base_d;
    logic                     oor_q,       oor_d;
    logic [ADDR_W-1:0]        sram_addr_q, sram_addr_d;
    logic [7:0]               sram_data_q, sram_data_d;
    logic                     we_q,        we_d;
    logic [7:0]               dout_q,      dout_d;
    logic                     buff_wr_q,   buff_wr_d;
    logic                     fetch_hi_q,  fetch_hi_d;

    // ------------------------------------------------------------------
    // Request edges, sector address arithmetic
    // ------------------------------------------------------------------
    logic              rd_edge;
    logic              wr_edge;
    logic [ADDR_W-1:0] new_base;
    logic              new_oor;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] next_addr;
    logic [SECTOR_SHIFT-1:0] next_cnt;
    logic              last_byte;
    logic              tmr_load;
    logic              tmr_zero;

    assign rd_edge = sd_rd & ~rd_q;
    assign wr_edge = sd_wr & ~wr_q;

    // lba*512 with the bits above ADDR_W dropped, which makes large LBAs wrap.
    assign new_base = ADDR_W'({sd_lba, {SECTOR_SHIFT{1'b0}}});

`ifdef SECTOR_RANGE_CHECK_EN
    logic [32:0] new_last_addr;
    assign new_last_addr = 33'(new_base) + 33'(LAST_BYTE);
    assign new_oor       = (new_last_addr >= {1'b0, img_size});
`else
    assign new_oor = 1'b0;
`endif

    assign next_cnt  = cnt_q + SECTOR_SHIFT'(1);
    assign cur_addr  = base_q + ADDR_W'(cnt_q);
    assign next_addr = base_q + ADDR_W'(next_cnt);
    assign last_byte = (cnt_q == LAST_BYTE);

    // ------------------------------------------------------------------
    // Wait-state timer, shared by RD_WAIT and WR_PULSE
    // ------------------------------------------------------------------
    sram_wait_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_timer (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .load_i  (tmr_load),
        .zero_o  (tmr_zero)
    );

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rd_d        = sd_rd;
        wr_d        = sd_wr;
        ack_d       = ack_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        oor_d       = oor_q;
        sram_addr_d = sram_addr_q;
        sram_data_d = sram_data_q;
        we_d        = we_q;
        dout_d      = dout_q;
        buff_wr_d   = 1'b0;
        fetch_hi_d  = fetch_hi_q;
        tmr_load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Edges are only looked at here; an edge while busy is
                // consumed by rd_q/wr_q and never replayed.
                if (rd_edge || wr_edge) begin
                    ack_d       = 1'b1;
                    cnt_d       = '0;
                    base_d      = new_base;
                    oor_d       = new_oor;
                    fetch_hi_d  = 1'b0;
                    // Out-of-range sectors leave the SRAM address at zero.
                    sram_addr_d = new_oor ? '0 : new_base;
                    state_d     = rd_edge ? ST_RD_ADDR : ST_WR_FETCH;
                end
            end

            ST_RD_ADDR: begin
                tmr_load = 1'b1;
                state_d  = ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
                if (tmr_zero) begin
                    dout_d    = oor_q ? 8'h00 : sram_data_i;
                    buff_wr_d = 1'b1;
                    state_d   = ST_RD_PUT;
                end
            end

            ST_RD_PUT: begin
                if (last_byte) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = next_cnt;
                    if (!oor_q) begin
                        sram_addr_d = next_addr;
                    end
                    state_d = ST_RD_ADDR;
                end
            end

            ST_WR_FETCH: begin
                // Two cycles: the first presents sd_buff_addr, the second
                // sees the buffer byte and loads the SRAM address/data.
                if (!fetch_hi_q) begin
                    fetch_hi_d = 1'b1;
                end else begin
                    fetch_hi_d = 1'b0;
                    tmr_load   = 1'b1;
                    if (!oor_q) begin
                        sram_data_d = sd_buff_din;
                        sram_addr_d = cur_addr;
                        we_d        = 1'b1;
                    end
                    state_d = ST_WR_PULSE;
                end
            end

            ST_WR_PULSE: begin
                if (tmr_zero) begin
                    we_d    = 1'b0;
                    state_d = ST_WR_HOLD;
                end
            end

            ST_WR_HOLD: begin
                if (last_byte) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = next_cnt;
                    state_d = ST_WR_FETCH;
                end
            end

            ST_DONE: begin
                ack_d   = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                ack_d   = 1'b0;
                we_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            ack_q       <= 1'b0;
            cnt_q       <= '0;
            base_q      <= '0;
            oor_q       <= 1'b0;
            sram_addr_q <= '0;
            sram_data_q <= 8'h00;
            we_q        <= 1'b0;
            dout_q      <= 8'h00;
            buff_wr_q   <= 1'b0;
            fetch_hi_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            ack_q       <= ack_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            oor_q       <= oor_d;
            sram_addr_q <= sram_addr_d;
            sram_data_q <= sram_data_d;
            we_q        <= we_d;
            dout_q      <= dout_d;
            buff_wr_q   <= buff_wr_d;
            fetch_hi_q  <= fetch_hi_d;
        end
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = cnt_q;
    assign sd_buff_dout = dout_q;
    assign sd_buff_wr   = buff_wr_q;
    assign sram_addr_o  = sram_addr_q;
    assign sram_data_o  = sram_data_q;
    assign sram_we_o    = we_q;

endmodule : sram_sector_server

// File: tb/tb_sram_sector_server.sv
// -----------------------------------------------------------------------------
// tb_sram_sector_server
//   Directed bench for sram_sector_server (ADDR_W=20, WAIT_CYCLES=2) with a
//   behavioural SRAM and FDC sector-buffer model. Build with
//   SECTOR_RANGE_CHECK_EN defined to exercise the image-size check.
// -----------------------------------------------------------------------------
module tb_sram_sector_server;

    localparam int ADDR_W      = 20;
    localparam int WAIT_CYCLES = 2;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic [31:0]       sd_lba  = '0;
    logic              sd_rd   = 1'b0;
    logic              sd_wr   = 1'b0;
    logic              sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic              sd_buff_wr;
    logic [7:0]        sd_buff_din = 8'h00;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [7:0]        sram_data_i;
    logic [7:0]        sram_data_o;
    logic              sram_we_o;
    logic [31:0]       img_size = 32'h0010_0000;

    always #5 clk_sys = ~clk_sys;

    sram_sector_server #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
`ifdef SECTOR_RANGE_CHECK_EN
        .img_size     (img_size),
`endif
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .sram_addr_o  (sram_addr_o),
        .sram_data_i  (sram_data_i),
        .sram_data_o  (sram_data_o),
        .sram_we_o    (sram_we_o)
    );

    // ---------------- SRAM model (asynchronous read, write on WE) -------------
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    assign sram_data_i = mem[sram_addr_o];
    always @(posedge clk_sys) begin
        if (sram_we_o) mem[sram_addr_o] <= sram_data_o;
    end

    // ---------------- FDC buffer model: byte n reads as 0xA5^n, 1-cycle lat ---
    always @(posedge clk_sys) sd_buff_din <= 8'hA5 ^ sd_buff_addr[7:0];

    // ---------------- Bus monitor ---------------------------------------------
    logic [7:0]        cap [0:511];
    int                ack_cycles = 0;
    int                strobes    = 0;
    int                seq_err    = 0;
    logic [8:0]        strobe_idx = '0;
    int                we_cycles  = 0;
    int                we_pulses  = 0;
    int                we_len_err = 0;
    int                we_unstable = 0;
    int                we_run     = 0;
    logic [ADDR_W-1:0] we_addr_prev = '0;
    logic [7:0]        we_data_prev = '0;

    always @(posedge clk_sys) begin
        if (sd_ack) ack_cycles++;
        if (sd_buff_wr) begin
            if (sd_buff_addr !== strobe_idx) seq_err++;
            cap[sd_buff_addr] = sd_buff_dout;
            strobe_idx++;
            strobes++;
        end
        if (sram_we_o) begin
            we_cycles++;
            if (we_run > 0 && (sram_addr_o !== we_addr_prev || sram_data_o !== we_data_prev))
                we_unstable++;
            we_run++;
            we_addr_prev = sram_addr_o;
            we_data_prev = sram_data_o;
        end else if (we_run > 0) begin
            we_pulses++;
            if (we_run != WAIT_CYCLES) we_len_err++;
            we_run = 0;
        end
    end

    // ---------------- Checking helpers ----------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] pat(input logic [19:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [47:0] all_outputs();
        return {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
                sram_addr_o, sram_data_o, sram_we_o};
    endfunction

    // Raise the given request levels for one edge; returns at the next negedge.
    task automatic request(input logic rd, input logic wr, input logic [31:0] lba);
        @(negedge clk_sys);
        sd_lba = lba;
        sd_rd  = rd;
        sd_wr  = wr;
        @(negedge clk_sys);
    endtask

    // Wait (bounded) for sd_ack to fall; counts cycles with a nonzero address.
    task automatic wait_idle(input string tag, output int addr_nz);
        int n;
        n       = 0;
        addr_nz = 0;
        while (sd_ack === 1'b1 && n < 20000) begin
            if (sram_addr_o !== '0) addr_nz++;
            @(negedge clk_sys);
            n++;
        end
        check({tag, "_ack_drop"}, 64'(sd_ack), 64'(1'b0));
        @(negedge clk_sys);
    endtask

    task automatic check_cap(input string tag, input logic [19:0] base, input logic zeros);
        int bad;
        logic [19:0] a;
        logic [7:0]  exp_b;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            a     = base + 20'(i);
            exp_b = zeros ? 8'h00 : pat(a);
            if (cap[i] !== exp_b) bad++;
        end
        check({tag, "_data"}, 64'(bad), 64'd0);
    endtask

    // ---------------- Directed sequence ---------------------------------------
    initial begin
        int a0, s0, q0, wc0, wp0, wl0, wu0, nz, n, bad;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = pat(20'(i));
        for (int i = 0; i < 512; i++) cap[i] = 8'hEE;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("reset_outputs", 64'(all_outputs()), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("idle_ack", 64'(sd_ack), 64'd0);

        // 1) Read LBA 3 -> SRAM 0x600..0x7FF
        a0 = ack_cycles; s0 = strobes; q0 = seq_err;
        request(1'b1, 1'b0, 32'd3);
        check("rd_ack_latency", 64'(sd_ack), 64'd1);
        check("rd_first_addr", 64'(sram_addr_o), 64'h600);
        sd_rd = 1'b0;
        wait_idle("rd", nz);
        check("rd_ack_cycles", 64'(ack_cycles - a0), 64'd2049);
        check("rd_strobes", 64'(strobes - s0), 64'd512);
        check("rd_strobe_order", 64'(seq_err - q0), 64'd0);
        check_cap("rd", 20'h600, 1'b0);
        check("rd_byte0", 64'(cap[0]), 64'h06);
        check("rd_byte256", 64'(cap[256]), 64'h07);
        check("rd_byte511", 64'(cap[511]), 64'hF8);

        // 2) Write LBA 1 -> SRAM 0x200..0x3FF gets 0xA5^n
        a0 = ack_cycles; wc0 = we_cycles; wp0 = we_pulses; wl0 = we_len_err; wu0 = we_unstable;
        request(1'b0, 1'b1, 32'd1);
        check("wr_ack_latency", 64'(sd_ack), 64'd1);
        sd_wr = 1'b0;
        wait_idle("wr", nz);
        check("wr_ack_cycles", 64'(ack_cycles - a0), 64'd2561);
        check("wr_pulses", 64'(we_pulses - wp0), 64'd512);
        check("wr_we_cycles", 64'(we_cycles - wc0), 64'd1024);
        check("wr_pulse_len", 64'(we_len_err - wl0), 64'd0);
        check("wr_stable", 64'(we_unstable - wu0), 64'd0);
        bad = 0;
        for (int i = 0; i < 512; i++)
            if (mem[20'h200 + 20'(i)] !== (8'hA5 ^ 8'(i))) bad++;
        check("wr_sram_data", 64'(bad), 64'd0);
        check("wr_below_untouched", 64'(mem[20'h1FF]), 64'hFE);
        check("wr_above_untouched", 64'(mem[20'h400]), 64'h04);

        // 3) Simultaneous rd/wr edges, then a second rd edge mid-transfer
        a0 = ack_cycles; s0 = strobes; wc0 = we_cycles;
        for (int i = 0; i < 512; i++) cap[i] = 8'hEE;
        request(1'b1, 1'b1, 32'd3);
        repeat (300) @(negedge clk_sys);
        sd_rd = 1'b0;
        @(negedge clk_sys);
        sd_rd = 1'b1;
        @(negedge clk_sys);
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        wait_idle("both", nz);
        check("both_strobes", 64'(strobes - s0), 64'd512);
        check("both_ack_cycles", 64'(ack_cycles - a0), 64'd2049);
        check("both_no_we", 64'(we_cycles - wc0), 64'd0);
        check_cap("both", 20'h600, 1'b0);

        // 4) Reset at byte 100 of a write to LBA 5 (0xA00)
        request(1'b0, 1'b1, 32'd5);
        sd_wr = 1'b0;
        n = 0;
        while (sd_buff_addr !== 9'd100 && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        check("rst_reach_byte100", 64'(sd_buff_addr), 64'd100);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_outputs", 64'(all_outputs()), 64'd0);
        @(negedge clk_sys);
        check("rst_held_outputs", 64'(all_outputs()), 64'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check("rst_byte50_written", 64'(mem[20'hA32]), 64'h97);
        check("rst_byte99_written", 64'(mem[20'hA63]), 64'hC6);
        check("rst_byte100_kept", 64'(mem[20'hA64]), 64'h6E);
        check("rst_byte200_kept", 64'(mem[20'hAC8]), 64'hC2);

        a0 = ack_cycles; s0 = strobes;
        for (int i = 0; i < 512; i++) cap[i] = 8'hEE;
        request(1'b1, 1'b0, 32'd3);
        sd_rd = 1'b0;
        wait_idle("post_rst", nz);
        check("post_rst_strobes", 64'(strobes - s0), 64'd512);
        check("post_rst_ack_cycles", 64'(ack_cycles - a0), 64'd2049);
        check_cap("post_rst", 20'h600, 1'b0);

        // 5) LBA 0x800 wraps to SRAM 0x00000
        s0 = strobes;
        for (int i = 0; i < 512; i++) cap[i] = 8'hEE;
        request(1'b1, 1'b0, 32'h800);
        check("wrap_first_addr", 64'(sram_addr_o), 64'h0);
        sd_rd = 1'b0;
        wait_idle("wrap", nz);
        check("wrap_strobes", 64'(strobes - s0), 64'd512);
        check_cap("wrap", 20'h00000, 1'b0);
        check("wrap_byte511", 64'(cap[511]), 64'hFE);

`ifdef SECTOR_RANGE_CHECK_EN
        // 6) Sector beyond the image: zero data, no address, no WE
        img_size = 32'h400;
        a0 = ack_cycles; s0 = strobes;
        for (int i = 0; i < 512; i++) cap[i] = 8'hEE;
        request(1'b1, 1'b0, 32'd2);
        sd_rd = 1'b0;
        wait_idle("oor_rd", nz);
        check("oor_rd_strobes", 64'(strobes - s0), 64'd512);
        check("oor_rd_ack_cycles", 64'(ack_cycles - a0), 64'd2049);
        check("oor_rd_addr_zero", 64'(nz), 64'd0);
        check_cap("oor_rd", 20'h400, 1'b1);

        a0 = ack_cycles; wc0 = we_cycles;
        request(1'b0, 1'b1, 32'd2);
        sd_wr = 1'b0;
        wait_idle("oor_wr", nz);
        check("oor_wr_ack_cycles", 64'(ack_cycles - a0), 64'd2561);
        check("oor_wr_no_we", 64'(we_cycles - wc0), 64'd0);
        check("oor_wr_mem_kept", 64'(mem[20'h400]), 64'h04);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sram_sector_server
